// File: rtl/cache_rd_arbiter_pkg.sv
// Shared definitions for the cache read arbiter: FSM encoding, requester ids,
// read type codes and the line-granular hazard compare.
package cache_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam logic ID_ICACHE = 1'b0;
    localparam logic ID_DCACHE = 1'b1;

    localparam logic [2:0] RD_BYTE = 3'b000;
    localparam logic [2:0] RD_HALF = 3'b001;
    localparam logic [2:0] RD_WORD = 3'b010;
    localparam logic [2:0] RD_LINE = 3'b100;

    // True when both addresses fall in the same line (low ofs bits ignored).
    function automatic logic same_line(input logic [31:0] a, input logic [31:0] b, input int ofs);
        return (a >> ofs) == (b >> ofs);
    endfunction

endpackage

// File: rtl/cache_rd_arbiter_prio_sel.sv
// Grant selection between icache and dcache with an icache starvation guard.
// dcache normally wins; icache is forced through after STARVE_LIMIT losses.
module rd_prio_sel #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic aclk,
    input  logic areset,
    input  logic arb_en,
    input  logic i_elig,
    input  logic d_elig,
    input  logic i_req,
    output logic grant_i,
    output logic grant_d
);

    logic [2:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt == 3'(STARVE_LIMIT));

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (arb_en) begin
            if (i_elig && starved)
                grant_i = 1'b1;
            else if (d_elig)
                grant_d = 1'b1;
            else if (i_elig)
                grant_i = 1'b1;
        end
    end

    // A loss counts whenever icache was asking, even if it was hazard-blocked.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            starve_cnt <= 3'd0;
        else if (grant_i)
            starve_cnt <= 3'd0;
        else if (grant_d && i_req && !starved)
            starve_cnt <= starve_cnt + 3'd1;
    end

endmodule

// File: rtl/cache_rd_arbiter.sv
// Merges icache and dcache reads onto a single-outstanding bridge read port,
// holding off reads that hit the line of an in-flight bridge write.
module cache_rd_arbiter
    import cache_rd_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int LINE_OFS     = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        icache_rd_req,
    input  logic [2:0]  icache_rd_type,
    input  logic [31:0] icache_rd_addr,
    output logic        icache_rd_rdy,
    output logic        icache_ret_valid,
    output logic        icache_ret_last,
    output logic [31:0] icache_ret_data,
    input  logic        dcache_rd_req,
    input  logic [2:0]  dcache_rd_type,
    input  logic [31:0] dcache_rd_addr,
    output logic        dcache_rd_rdy,
    output logic        dcache_ret_valid,
    output logic        dcache_ret_last,
    output logic [31:0] dcache_ret_data,
    input  logic        wr_pending,
    input  logic [31:0] wr_pending_addr,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    output logic        rd_id,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data
);

    arb_state_t  state, state_nxt;
    logic        arb_en, i_elig, d_elig, grant_i, grant_d;
    logic [2:0]  type_q;
    logic [31:0] addr_q;
    logic        id_q;
    logic        fwd_i, fwd_d;

    assign i_elig = icache_rd_req && !(wr_pending && same_line(icache_rd_addr, wr_pending_addr, LINE_OFS));
    assign d_elig = dcache_rd_req && !(wr_pending && same_line(dcache_rd_addr, wr_pending_addr, LINE_OFS));
    // Gating on areset keeps the combinational rdy low while reset is held.
    assign arb_en = (state == ST_IDLE) && !areset;

    rd_prio_sel #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
        .aclk    (aclk),
        .areset  (areset),
        .arb_en  (arb_en),
        .i_elig  (i_elig),
        .d_elig  (d_elig),
        .i_req   (icache_rd_req),
        .grant_i (grant_i),
        .grant_d (grant_d)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (grant_i || grant_d)     state_nxt = ST_REQ;
            ST_REQ:  if (rd_rdy)                 state_nxt = ST_RESP;
            ST_RESP: if (ret_valid && ret_last)  state_nxt = ST_IDLE;
            default:                             state_nxt = ST_IDLE;
        endcase
    end

    // Request is captured at grant so later wr_pending changes cannot disturb it.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            type_q <= 3'd0;
            addr_q <= 32'd0;
            id_q   <= 1'b0;
        end else if (grant_i) begin
            type_q <= icache_rd_type;
            addr_q <= icache_rd_addr;
            id_q   <= ID_ICACHE;
        end else if (grant_d) begin
            type_q <= dcache_rd_type;
            addr_q <= dcache_rd_addr;
            id_q   <= ID_DCACHE;
        end
    end

    always_comb begin
        icache_rd_rdy    = grant_i;
        dcache_rd_rdy    = grant_d;
        rd_req           = (state == ST_REQ);
        rd_type          = type_q;
        rd_addr          = addr_q;
        rd_id            = id_q;
        fwd_i            = (state == ST_RESP) && ret_valid && (id_q == ID_ICACHE);
        fwd_d            = (state == ST_RESP) && ret_valid && (id_q == ID_DCACHE);
        icache_ret_valid = fwd_i;
        icache_ret_last  = fwd_i && ret_last;
        icache_ret_data  = fwd_i ? ret_data : 32'd0;
        dcache_ret_valid = fwd_d;
        dcache_ret_last  = fwd_d && ret_last;
        dcache_ret_data  = fwd_d ? ret_data : 32'd0;
    end

endmodule
